// File: rtl/instr_encoder_if.sv
// Instruction-field input and byte-stream output bundle for instr_encoder.
// The master is the side that drives fields and consumes bytes; the slave is the encoder.
interface instr_encoder_if;
  logic        in_valid;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valC;
  logic        in_ready;
  logic        addr_load;
  logic [7:0]  addr_in;
  logic        out_valid;
  logic [7:0]  out_byte;
  logic [7:0]  out_addr;
  logic        out_last;
  logic        out_ready;
  logic        err_invalid;
  logic        err_imem;
  logic        halt_flag;

  modport master (
    output in_valid, icode, ifun, rA, rB, valC, addr_load, addr_in, out_ready,
    input  in_ready, out_valid, out_byte, out_addr, out_last,
           err_invalid, err_imem, halt_flag
  );

  modport slave (
    input  in_valid, icode, ifun, rA, rB, valC, addr_load, addr_in, out_ready,
    output in_ready, out_valid, out_byte, out_addr, out_last,
           err_invalid, err_imem, halt_flag
  );
endinterface

// File: rtl/instr_encoder.sv
// Y86-style instruction encoder: turns instruction fields into a byte stream for instruction memory.
// Optional macro HALT_LOCK_EN: icode 0 sets a sticky halt flag and locks the encoder until reset.
module instr_encoder (
  input  logic            clk,
  input  logic            rst_n,
  instr_encoder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT   = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [79:0] buf_q, buf_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_invalid_q, err_invalid_d;
  logic        err_imem_q, err_imem_d;
  logic [3:0]  len;
  logic        idle_ready;

`ifdef HALT_LOCK_EN
  logic        halt_q, halt_d;
  logic        halt_pend_q, halt_pend_d;
`endif

  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       instr_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
      4'h7, 4'h8:             instr_len = 4'd9;
      4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
      default:                instr_len = 4'd0;
    endcase
  endfunction

  // Bytes are packed left-justified so the stream is just the top byte of a shifting buffer.
  function automatic logic [79:0] pack(input logic [3:0] l, input logic [3:0] ic,
                                       input logic [3:0] fn, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [63:0] vc);
    case (l)
      4'd2:    pack = {ic, fn, ra, rb, 64'h0};
      4'd9:    pack = {ic, fn, vc, 8'h00};
      4'd10:   pack = {ic, fn, ra, rb, vc};
      default: pack = {ic, fn, 72'h0};
    endcase
  endfunction

  assign idle_ready = (state_q == IDLE) && !bus.addr_load;
  assign len        = instr_len(bus.icode);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    buf_d         = buf_q;
    cnt_d         = cnt_q;
    err_invalid_d = 1'b0;
    err_imem_d    = 1'b0;
`ifdef HALT_LOCK_EN
    halt_d        = halt_q;
    halt_pend_d   = halt_pend_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.addr_load) begin
          addr_d = bus.addr_in;
        end else if (bus.in_valid) begin
          // Invalid icode takes priority so the two error pulses are mutually exclusive.
          if (len == 4'd0) begin
            err_invalid_d = 1'b1;
          end else if (({1'b0, addr_q} + {5'b0, len}) > 9'd256) begin
            err_imem_d = 1'b1;
          end else begin
            state_d = EMIT;
            buf_d   = pack(len, bus.icode, bus.ifun, bus.rA, bus.rB, bus.valC);
            cnt_d   = len;
`ifdef HALT_LOCK_EN
            halt_pend_d = (bus.icode == 4'h0);
`endif
          end
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          addr_d = addr_q + 8'd1;
          buf_d  = {buf_q[71:0], 8'h00};
          cnt_d  = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = IDLE;
`ifdef HALT_LOCK_EN
            if (halt_pend_q) begin
              state_d = HALTED;
              halt_d  = 1'b1;
            end
`endif
          end
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      buf_q         <= '0;
      cnt_q         <= '0;
      err_invalid_q <= 1'b0;
      err_imem_q    <= 1'b0;
`ifdef HALT_LOCK_EN
      halt_q        <= 1'b0;
      halt_pend_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      buf_q         <= buf_d;
      cnt_q         <= cnt_d;
      err_invalid_q <= err_invalid_d;
      err_imem_q    <= err_imem_d;
`ifdef HALT_LOCK_EN
      halt_q        <= halt_d;
      halt_pend_q   <= halt_pend_d;
`endif
    end
  end

  assign bus.in_ready    = rst_n && idle_ready;
  assign bus.out_valid   = (state_q == EMIT);
  assign bus.out_byte    = buf_q[79:72];
  assign bus.out_addr    = addr_q;
  assign bus.out_last    = (state_q == EMIT) && (cnt_q == 4'd1);
  assign bus.err_invalid = err_invalid_q;
  assign bus.err_imem    = err_imem_q;
`ifdef HALT_LOCK_EN
  assign bus.halt_flag   = halt_q;
`else
  assign bus.halt_flag   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder; expected bytes are hand-encoded per instruction.
module tb_instr_encoder;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_err = 0;

  instr_encoder_if bus ();

  instr_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_addr(input logic [7:0] a);
    bus.addr_load = 1'b1;
    bus.addr_in   = a;
    @(negedge clk);
    bus.addr_load = 1'b0;
  endtask

  task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [63:0] vc);
    for (int t = 0; t < 20 && !bus.in_ready; t++) @(negedge clk);
    if (!bus.in_ready) check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
    bus.icode    = ic;
    bus.ifun     = fn;
    bus.rA       = ra;
    bus.rB       = rb;
    bus.valC     = vc;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(input int n, input int len, input logic [7:0] eb [10],
                         input logic [7:0] a0, input bit stall);
    for (int i = 0; i < n; i++) begin
      for (int t = 0; t < 20 && !bus.out_valid; t++) @(negedge clk);
      if (!bus.out_valid) begin
        check("out_valid_timeout", 64'(bus.out_valid), 64'd1);
        return;
      end
      if (stall) begin
        bus.out_ready = 1'b0;
        check($sformatf("byte%0d", i), 64'(bus.out_byte), 64'(eb[i]));
        @(negedge clk);
        check($sformatf("hold_valid%0d", i), 64'(bus.out_valid), 64'd1);
        check($sformatf("hold_byte%0d", i), 64'(bus.out_byte), 64'(eb[i]));
        check($sformatf("hold_addr%0d", i), 64'(bus.out_addr), 64'(a0 + 8'(i)));
        check($sformatf("hold_last%0d", i), 64'(bus.out_last), 64'(i == len - 1));
        bus.out_ready = 1'b1;
      end else begin
        check($sformatf("byte%0d", i), 64'(bus.out_byte), 64'(eb[i]));
        check($sformatf("addr%0d", i), 64'(bus.out_addr), 64'(a0 + 8'(i)));
        check($sformatf("last%0d", i), 64'(bus.out_last), 64'(i == len - 1));
      end
      @(negedge clk);
    end
  endtask

  logic [7:0] eb [10];
  int         seen;

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.icode = '0; bus.ifun = '0; bus.rA = '0; bus.rB = '0;
    bus.valC = '0; bus.addr_load = 1'b0; bus.addr_in = '0; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_addr", 64'(bus.out_addr), 64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_byte", 64'(bus.out_byte), 64'd0);
    check("rst_last", 64'(bus.out_last), 64'd0);
    check("rst_errs", 64'({bus.err_invalid, bus.err_imem, bus.halt_flag}), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // irmovq $0x100, %rdx at address 0
    send(4'h3, 4'h0, 4'hF, 4'h2, 64'h0000_0000_0000_0100);
    eb = '{8'h30, 8'hF2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
    collect(10, 10, eb, 8'd0, 1'b0);
    check("irmov_idle_valid", 64'(bus.out_valid), 64'd0);
    check("irmov_idle_ready", 64'(bus.in_ready), 64'd1);

    // addq with a stalling consumer
    load_addr(8'd0);
    send(4'h6, 4'h0, 4'h1, 4'h2, 64'h0);
    eb = '{8'h60, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    collect(2, 2, eb, 8'd0, 1'b1);
    check("opq_done_valid", 64'(bus.out_valid), 64'd0);

    // invalid icode at address 5
    load_addr(8'd5);
    send(4'hC, 4'h0, 4'h0, 4'h0, 64'h0);
    check("inv_pulse", 64'(bus.err_invalid), 64'd1);
    check("inv_no_imem", 64'(bus.err_imem), 64'd0);
    check("inv_valid", 64'(bus.out_valid), 64'd0);
    check("inv_addr", 64'(bus.out_addr), 64'd5);
    @(negedge clk);
    check("inv_pulse_end", 64'(bus.err_invalid), 64'd0);
    check("inv_valid2", 64'(bus.out_valid), 64'd0);
    send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0);
    eb = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    collect(1, 1, eb, 8'd5, 1'b0);

    // call overflowing memory, then invalid icode at the same address takes priority
    load_addr(8'd250);
    send(4'h8, 4'h0, 4'h0, 4'h0, 64'h40);
    check("imem_pulse", 64'(bus.err_imem), 64'd1);
    check("imem_no_inv", 64'(bus.err_invalid), 64'd0);
    check("imem_valid", 64'(bus.out_valid), 64'd0);
    check("imem_addr", 64'(bus.out_addr), 64'd250);
    @(negedge clk);
    check("imem_pulse_end", 64'(bus.err_imem), 64'd0);
    send(4'hD, 4'h0, 4'h0, 4'h0, 64'h0);
    check("prio_inv", 64'(bus.err_invalid), 64'd1);
    check("prio_no_imem", 64'(bus.err_imem), 64'd0);
    send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0);
    collect(1, 1, eb, 8'd250, 1'b0);

    // exactly fits: 246 + 10 = 256; one more byte does not
    load_addr(8'd247);
    send(4'h4, 4'h0, 4'h1, 4'h2, 64'h0102_0304_0506_0708);
    check("edge_reject", 64'(bus.err_imem), 64'd1);
    check("edge_reject_valid", 64'(bus.out_valid), 64'd0);
    load_addr(8'd246);
    send(4'h4, 4'h0, 4'h1, 4'h2, 64'h0102_0304_0506_0708);
    check("edge_accept_noerr", 64'(bus.err_imem), 64'd0);
    eb = '{8'h40, 8'h12, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    collect(10, 10, eb, 8'd246, 1'b0);

    // halt at address 3
    load_addr(8'd3);
    send(4'h0, 4'h0, 4'h0, 4'h0, 64'h0);
    eb = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    collect(1, 1, eb, 8'd3, 1'b0);
    check("halt_valid", 64'(bus.out_valid), 64'd0);
`ifdef HALT_LOCK_EN
    check("halt_flag", 64'(bus.halt_flag), 64'd1);
    check("halt_ready", 64'(bus.in_ready), 64'd0);
    repeat (3) @(negedge clk);
    check("halt_stuck_ready", 64'(bus.in_ready), 64'd0);
    check("halt_stuck_flag", 64'(bus.halt_flag), 64'd1);
    rst_n = 1'b0;
    #1;
    check("halt_rst_flag", 64'(bus.halt_flag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("halt_release_ready", 64'(bus.in_ready), 64'd1);
`else
    check("nohalt_flag", 64'(bus.halt_flag), 64'd0);
    check("nohalt_ready", 64'(bus.in_ready), 64'd1);
`endif

    // reset in the middle of a 10-byte rmmovq
    load_addr(8'd0);
    send(4'h4, 4'h0, 4'h1, 4'h2, 64'h1122_3344_5566_7788);
    eb = '{8'h40, 8'h12, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    collect(5, 10, eb, 8'd0, 1'b0);
    check("mid_valid", 64'(bus.out_valid), 64'd1);
    check("mid_byte", 64'(bus.out_byte), 64'h44);
    rst_n = 1'b0;
    #1;
    check("abort_valid", 64'(bus.out_valid), 64'd0);
    check("abort_addr", 64'(bus.out_addr), 64'd0);
    check("abort_byte", 64'(bus.out_byte), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("abort_no_bytes", 64'(seen), 64'd0);
    check("abort_ready", 64'(bus.in_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have inputs in_valid (1), icode (4), ifun (4), rA (4), rB (4), valC (64): instruction fields offered for encoding.
REQ-004 SHALL have output in_ready (1): encoder accepts fields when in_valid && in_ready.
REQ-005 SHALL have inputs addr_load (1) and addr_in (8): load the instruction-memory write address.
REQ-006 SHALL have outputs out_valid (1), out_byte (8), out_addr (8), out_last (1), plus input out_ready (1): byte stream to instruction memory.
REQ-007 SHALL have outputs err_invalid (1), err_imem (1), halt_flag (1): status.

Function
REQ-008 SHALL implement FSM states IDLE, EMIT and HALTED; in_ready = 1 only in IDLE with addr_load low.
REQ-009 SHALL capture all fields on accept; first byte valid the cycle after accept.
REQ-010 SHALL set instruction length by icode: 0, 1, 9 -> 1 byte; 2, 6, A, B -> 2 bytes; 7, 8 -> 9 bytes; 3, 4, 5 -> 10 bytes.
REQ-011 SHALL order bytes as follows: byte0 = {icode, ifun}; next, if the length is 2 or 10, {rA, rB}; then, if the length is 9 or 10, valC most-significant byte first.
REQ-012 SHALL hold out_byte, out_addr and out_last stable while out_valid && !out_ready; advance one byte per out_valid && out_ready.
REQ-013 SHALL increment out_addr by 1 per transferred byte; out_last = 1 on an instruction's final byte; after the final transfer, return to IDLE (one idle cycle minimum between instructions).
REQ-014 SHALL treat icode > 4'hB as invalid: accept it, emit no bytes, pulse err_invalid for 1 cycle the cycle after accept, and leave the address unchanged.
REQ-015 SHALL reject an instruction whose address + length > 256: emit no bytes, pulse err_imem for 1 cycle the cycle after accept, and leave the address unchanged; it SHALL NOT wrap.
REQ-016 SHALL check invalid icode before address range; both errors never pulse together.
REQ-017 SHALL set out_addr = addr_in on addr_load in IDLE; addr_load outside IDLE is ignored.
REQ-018 SHALL hold out_valid low in IDLE and HALTED.

Reset
REQ-019 SHALL, on rst_n low, immediately force state IDLE, out_addr 0, out_valid 0, out_byte 0, out_last 0, err_invalid 0, err_imem 0 and halt_flag 0; in_ready is 1 only after rst_n deasserts.
REQ-020 SHALL abandon any partially emitted instruction on reset mid-EMIT; no further bytes of it appear.

Configuration
REQ-021 SHALL define macro HALT_LOCK_EN: when defined, halt handling is compiled in; when undefined, the halt logic is compiled out.
REQ-022 SHALL, with HALT_LOCK_EN defined, set halt_flag sticky and enter HALTED after the final byte of icode 0 transfers; HALTED holds in_ready 0 until reset.
REQ-023 SHALL, without HALT_LOCK_EN, treat icode 0 as an ordinary 1-byte instruction, tie halt_flag to 0, and never enter HALTED.

Verification
REQ-024 SHALL cover: addr 0, irmovq icode=3 ifun=0 rA=F rB=2 valC=0x0000000000000100, out_ready=1 -> bytes 30 F2 00 00 00 00 00 00 01 00 at addr 0..9, out_last on byte 9, then IDLE.
REQ-025 SHALL cover: OPq 6/0 rA=1 rB=2 with out_ready toggling 0,1,0,1 -> bytes 60 then 12, each held stable while stalled, addr 0 and 1.
REQ-026 SHALL cover: icode=C accepted at addr 5 -> err_invalid 1-cycle pulse, out_valid stays 0, next instruction written at addr 5.
REQ-027 SHALL cover: addr_load 250 then call 8/0 valC=0x40 -> err_imem pulse, no bytes, out_addr stays 250; then nop -> byte 10 at addr 250.
REQ-028 SHALL cover: HALT_LOCK_EN defined, halt at addr 3 -> byte 00 at addr 3, halt_flag 1, in_ready 0 until rst_n pulse; with the macro undefined -> in_ready returns 1 and halt_flag stays 0.
REQ-029 SHALL cover: rst_n asserted after byte 4 of a 10-byte rmmovq -> out_valid 0 immediately, out_addr 0, no remaining bytes.
